mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Accepts each stage's request and arbitrates between them.
- Runs one bus transaction at a time over a req/ack handshake.
- Returns registered read data and a one-cycle Ack to the winner.
- Drives a global pipeline stall while any stage waits.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 64, maximum cycles to wait for bus ack before the transfer is aborted.
- ERR_DATA, 32'hDEADBEEF, read data returned on an aborted transfer.

Ports:
- clk  in  1  system clock; rising edge.
- nrst  in  1  asynchronous, active-low reset.
- i_IF_mem_Req  in  1  instruction fetch request (read only).
- i_IF_mem_Addr  in  ADDR_W  fetch address.
- o_IF_mem_Data  out  DATA_W  fetched word, registered.
- o_IF_mem_Ack  out  1  one-cycle completion pulse to IF.
- i_MEM_mem_MemRead  in  1  load request.
- i_MEM_mem_MemWrite  in  1  store request.
- i_MEM_mem_DmemAddr  in  ADDR_W  load/store address.
- i_MEM_mem_DmemDataW  in  DATA_W  store data.
- o_MEM_mem_DmemDataR  out  DATA_W  load data, registered.
- o_MEM_mem_Ack  out  1  one-cycle completion pulse to MEM.
- o_BUS_Req  out  1  memory request, held until ack.
- o_BUS_We  out  1  1 = write, 0 = read.
- o_BUS_Addr  out  ADDR_W  latched address.
- o_BUS_DataW  out  DATA_W  latched write data.
- i_BUS_DataR  in  DATA_W  read data, valid with i_BUS_Ack.
- i_BUS_Ack  in  1  memory completion, one cycle.
- o_CTRL_Stall  out  1  pipeline stall.
- o_CTRL_Timeout  out  1  sticky abort flag.

Behaviour:
- Reset (async, nrst=0):
  - All outputs are 0, including the data registers.
  - FSM goes to IDLE; the last_mem bit is cleared.
  - o_BUS_Req drops immediately, even mid-transfer; the in-flight transfer is lost with no Ack.
- FSM states: IDLE, BUSY_IF, BUSY_MEM.
- Request definitions:
  - mem_req = MemRead | MemWrite. MemRead=MemWrite=1 is treated as a write.
  - A requester whose Ack is high in the current cycle is masked in IDLE, so the same request is never granted twice.
- IDLE:
  - If only one unmasked request is present, grant it.
  - If both are present: MEM wins unless last_mem=1, in which case IF wins. Alternation prevents starvation.
  - On grant, latch address, write data and We into the o_BUS_* registers and set o_BUS_Req=1 on the next edge.
  - last_mem records the winner.
- BUSY_x:
  - o_BUS_Req and the latched fields stay stable until i_BUS_Ack=1.
  - On ack: capture i_BUS_DataR into the winner's data register (reads only; a write leaves DMemDataR unchanged) and pulse the winner's Ack for one cycle.
  - On the same edge: drop o_BUS_Req and return to IDLE.
- Latency:
  - Request seen in cycle 0; o_BUS_Req is high in cycle 1.
  - Ack at the earliest in cycle 2, when memory acks in cycle 1.
  - Next transfer's o_BUS_Req is at the earliest in cycle 3; no back-to-back bus cycles.
- Requester contract:
  - Requesters hold their request until Ack.
  - If a request drops mid-transfer, the transfer still completes and the Ack still pulses.
  - Input changes during BUSY are ignored.
- Stall (combinational):
  - o_CTRL_Stall = (i_IF_mem_Req & ~o_IF_mem_Ack) | (mem_req & ~o_MEM_mem_Ack).
- Timeout:
  - An 8-bit counter clears on grant and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYC-1 with no ack: drop o_BUS_Req, return ERR_DATA on a read, pulse the winner's Ack, set o_CTRL_Timeout and go to IDLE.
  - o_CTRL_Timeout clears only on reset.
  - An ack in the same cycle as the timeout wins: this is a normal completion and the flag is not set.
- i_BUS_Ack received in IDLE is ignored.

Decomposition:
- Shared package (mips_pkg):
  - FSM state encoding: IDLE=2'd0, BUSY_IF=2'd1, BUSY_MEM=2'd2.
  - Grant-ID constants GNT_IF and GNT_MEM.
  - ERR_DATA default.
- Sub-module arb_rr2: two-requester priority/alternation picker with the last_mem register and mask inputs.
- FSM, timeout counter and bus registers stay in the top level.

Test Plan:
- Single IF read: IF Req, Addr=0x100; memory acks 3 cycles after o_BUS_Req with 0x2402000A.
  - o_BUS_We=0 and o_BUS_Addr=0x100 held 3 cycles.
  - o_IF_mem_Data=0x2402000A; o_IF_mem_Ack pulses 1 cycle.
  - Stall high from cycle 0 until the Ack cycle.
- Simultaneous requests after reset: IF 0x104, and MEM MemWrite to 0x2000 with 0x55.
  - MEM granted first (o_BUS_We=1, o_BUS_DataW=0x55), then IF 0x104.
  - o_MEM_mem_DmemDataR unchanged.
- Alternation: IF and MEM both requesting continuously, zero-wait memory.
  - Bus grants alternate MEM, IF, MEM, IF.
  - Each Ack pulses exactly once per transfer; no double grant in the Ack cycle.
- Timeout: MEM MemRead to 0x3000, memory never acks.
  - Abort after 64 BUSY cycles.
  - o_MEM_mem_DmemDataR=0xDEADBEEF, o_MEM_mem_Ack pulses, o_CTRL_Timeout=1 sticky.
  - A subsequent IF read completes normally with the flag still 1.
- Reset mid-transfer: nrst low in BUSY_IF.
  - o_BUS_Req=0 at once, no Ack, all outputs 0.
  - After release, a held IF request is re-granted from IDLE.
- Ack and timeout in the same cycle: i_BUS_Ack=1 with 0x77 in the 64th BUSY cycle.
  - Data 0x77 returned; o_CTRL_Timeout stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared state encoding, grant IDs and constants for the unified memory port arbiter.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_e;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int          TMO_CNT_W        = 8;

  function automatic arb_state_e busy_state(input logic gnt_id);
    return (gnt_id == GNT_MEM) ? BUSY_MEM : BUSY_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-requester picker: MEM has priority unless it won last time, which keeps IF from starving.
module arb_rr2
  import mips_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic req_if,
  input  logic req_mem,
  input  logic mask_if,
  input  logic mask_mem,
  input  logic upd_en,
  output logic gnt_vld,
  output logic gnt_id
);

  logic last_mem_q, last_mem_d;
  logic eff_if, eff_mem;

  always_comb begin
    eff_if     = req_if  & ~mask_if;
    eff_mem    = req_mem & ~mask_mem;
    gnt_vld    = eff_if | eff_mem;
    gnt_id     = (eff_mem & (~eff_if | ~last_mem_q)) ? GNT_MEM : GNT_IF;
    last_mem_d = last_mem_q;
    if (upd_en && gnt_vld) last_mem_d = (gnt_id == GNT_MEM);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) last_mem_q <= 1'b0;
    else       last_mem_q <= last_mem_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store; one bus
// transaction at a time, registered data/ack back to the winner, sticky abort on timeout.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT_CYC = 64,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_IF_mem_Req,
  input  logic [ADDR_W-1:0] i_IF_mem_Addr,
  output logic [DATA_W-1:0] o_IF_mem_Data,
  output logic              o_IF_mem_Ack,
  input  logic              i_MEM_mem_MemRead,
  input  logic              i_MEM_mem_MemWrite,
  input  logic [ADDR_W-1:0] i_MEM_mem_DmemAddr,
  input  logic [DATA_W-1:0] i_MEM_mem_DmemDataW,
  output logic [DATA_W-1:0] o_MEM_mem_DmemDataR,
  output logic              o_MEM_mem_Ack,
  output logic              o_BUS_Req,
  output logic              o_BUS_We,
  output logic [ADDR_W-1:0] o_BUS_Addr,
  output logic [DATA_W-1:0] o_BUS_DataW,
  input  logic [DATA_W-1:0] i_BUS_DataR,
  input  logic              i_BUS_Ack,
  output logic              o_CTRL_Stall,
  output logic              o_CTRL_Timeout
);

  arb_state_e           state_q, state_d;
  logic                 bus_req_q, bus_req_d;
  logic                 bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]    bus_dataw_q, bus_dataw_d;
  logic [DATA_W-1:0]    if_data_q, if_data_d;
  logic [DATA_W-1:0]    mem_data_q, mem_data_d;
  logic                 if_ack_q, if_ack_d;
  logic                 mem_ack_q, mem_ack_d;
  logic                 tmo_q, tmo_d;
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

  logic              mem_req;
  logic              gnt_vld, gnt_id;
  logic              tmo_hit;
  logic [DATA_W-1:0] rd_data;

  assign mem_req = i_MEM_mem_MemRead | i_MEM_mem_MemWrite;

  // A requester whose Ack is showing this cycle is already served; masking it
  // stops the same held request from being granted a second time.
  arb_rr2 u_arb (
    .clk      (clk),
    .nrst     (nrst),
    .req_if   (i_IF_mem_Req),
    .req_mem  (mem_req),
    .mask_if  (if_ack_q),
    .mask_mem (mem_ack_q),
    .upd_en   (state_q == IDLE),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  assign tmo_hit = (cnt_q == TMO_CNT_W'(TIMEOUT_CYC - 1));
  assign rd_data = i_BUS_Ack ? i_BUS_DataR : ERR_DATA;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_dataw_d = bus_dataw_q;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d   = busy_state(gnt_id);
          bus_req_d = 1'b1;
          cnt_d     = '0;
          if (gnt_id == GNT_MEM) begin
            bus_we_d    = i_MEM_mem_MemWrite;
            bus_addr_d  = i_MEM_mem_DmemAddr;
            bus_dataw_d = i_MEM_mem_DmemDataW;
          end else begin
            bus_we_d   = 1'b0;
            bus_addr_d = i_IF_mem_Addr;
          end
        end
      end
      BUSY_IF, BUSY_MEM: begin
        // An ack on the final allowed cycle is a normal completion.
        if (i_BUS_Ack || tmo_hit) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (!i_BUS_Ack) tmo_d = 1'b1;
          if (state_q == BUSY_IF) begin
            if_data_d = rd_data;
            if_ack_d  = 1'b1;
          end else begin
            if (!bus_we_q) mem_data_d = rd_data;
            mem_ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_dataw_q <= '0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      tmo_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_dataw_q <= bus_dataw_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_IF_mem_Data       = if_data_q;
  assign o_IF_mem_Ack        = if_ack_q;
  assign o_MEM_mem_DmemDataR = mem_data_q;
  assign o_MEM_mem_Ack       = mem_ack_q;
  assign o_BUS_Req           = bus_req_q;
  assign o_BUS_We            = bus_we_q;
  assign o_BUS_Addr          = bus_addr_q;
  assign o_BUS_DataW         = bus_dataw_q;
  assign o_CTRL_Timeout      = tmo_q;
  assign o_CTRL_Stall        = (i_IF_mem_Req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

  localparam int          TMO  = 64;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0, nrst = 1'b0;
  logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, bus_ack = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_dw = '0, bus_dr = '0;
  logic [31:0] if_data, mem_data, b_addr, b_dw;
  logic        if_ack, mem_ack, b_req, b_we, stall, tmo;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .nrst(nrst),
    .i_IF_mem_Req(if_req), .i_IF_mem_Addr(if_addr),
    .o_IF_mem_Data(if_data), .o_IF_mem_Ack(if_ack),
    .i_MEM_mem_MemRead(mem_rd), .i_MEM_mem_MemWrite(mem_wr),
    .i_MEM_mem_DmemAddr(mem_addr), .i_MEM_mem_DmemDataW(mem_dw),
    .o_MEM_mem_DmemDataR(mem_data), .o_MEM_mem_Ack(mem_ack),
    .o_BUS_Req(b_req), .o_BUS_We(b_we), .o_BUS_Addr(b_addr), .o_BUS_DataW(b_dw),
    .i_BUS_DataR(bus_dr), .i_BUS_Ack(bus_ack),
    .o_CTRL_Stall(stall), .o_CTRL_Timeout(tmo)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by owner and age.
  logic        e_req = 0, e_we = 0, e_if_ack = 0, e_mem_ack = 0, e_tmo = 0;
  logic [31:0] e_addr = 0, e_dw = 0, e_if_data = 0, e_mem_data = 0;
  bit          busy = 0, owner_mem = 0, last_mem = 0;
  int          age = 0;

  initial begin : model
    bit pa_if, pa_mem, w_if, w_mem;
    logic [31:0] rdv;
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        e_req = 0; e_we = 0; e_addr = 0; e_dw = 0; e_if_data = 0; e_mem_data = 0;
        e_if_ack = 0; e_mem_ack = 0; e_tmo = 0; busy = 0; owner_mem = 0; age = 0; last_mem = 0;
      end else begin
        pa_if = e_if_ack; pa_mem = e_mem_ack;
        e_if_ack = 0; e_mem_ack = 0;
        if (busy) begin
          age++;
          if (bus_ack || age == TMO) begin
            rdv = bus_ack ? bus_dr : ERRD;
            if (!bus_ack) e_tmo = 1;
            if (owner_mem) begin
              e_mem_ack = 1;
              if (!e_we) e_mem_data = rdv;
            end else begin
              e_if_ack = 1; e_if_data = rdv;
            end
            busy = 0; e_req = 0;
          end
        end else begin
          w_if  = if_req && !pa_if;
          w_mem = (mem_rd || mem_wr) && !pa_mem;
          if (w_if || w_mem) begin
            owner_mem = w_mem && (!w_if || !last_mem);
            last_mem = owner_mem; busy = 1; age = 0; e_req = 1;
            if (owner_mem) begin e_we = mem_wr; e_addr = mem_addr; e_dw = mem_dw; end
            else begin e_we = 0; e_addr = if_addr; end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("bus_req", b_req, e_req);
    chk("bus_we", b_we, e_we);
    chk("bus_addr", b_addr, e_addr);
    chk("bus_dataw", b_dw, e_dw);
    chk("if_data", if_data, e_if_data);
    chk("if_ack", if_ack, e_if_ack);
    chk("mem_data", mem_data, e_mem_data);
    chk("mem_ack", mem_ack, e_mem_ack);
    chk("timeout", tmo, e_tmo);
    chk("stall", stall, (if_req & ~e_if_ack) | ((mem_rd | mem_wr) & ~e_mem_ack));
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    nrst = 0; if_req = 0; mem_rd = 0; mem_wr = 0; bus_ack = 0;
    step; step;
    nrst = 1;
  endtask

  logic [31:0] seq [4];
  int n, ifa, mema, cnt, wait_left, r, lat;

  initial begin
    // Reset state
    step; step;
    chk("rst_bus_req", b_req, 0); chk("rst_if_data", if_data, 0);
    chk("rst_mem_data", mem_data, 0); chk("rst_tmo", tmo, 0); chk("rst_stall", stall, 0);
    nrst = 1;
    step;

    // Single IF read, memory acks on the third bus cycle
    if_req = 1; if_addr = 32'h100; #1;
    chk("if1_stall_c0", stall, 1);
    step;
    for (int k = 1; k <= 3; k++) begin
      chk("if1_bus_req", b_req, 1); chk("if1_we", b_we, 0);
      chk("if1_addr", b_addr, 32'h100); chk("if1_stall", stall, 1);
      if (k == 3) begin bus_ack = 1; bus_dr = 32'h2402000A; end
      step;
    end
    chk("if1_ack", if_ack, 1); chk("if1_data", if_data, 32'h2402000A);
    chk("if1_req_drop", b_req, 0); chk("if1_stall_ack", stall, 0);
    bus_ack = 0; if_req = 0;
    step;
    chk("if1_ack_pulse", if_ack, 0); chk("if1_data_hold", if_data, 32'h2402000A);

    // Simultaneous requests after reset: MEM write first, then IF
    do_reset;
    if_req = 1; if_addr = 32'h104; mem_wr = 1; mem_addr = 32'h2000; mem_dw = 32'h55;
    step;
    chk("sim_req", b_req, 1); chk("sim_we", b_we, 1);
    chk("sim_addr", b_addr, 32'h2000); chk("sim_dw", b_dw, 32'h55);
    bus_ack = 1; bus_dr = 32'hAAAA5555;
    step;
    chk("sim_mem_ack", mem_ack, 1); chk("sim_mem_data", mem_data, 0); chk("sim_if_ack", if_ack, 0);
    bus_ack = 0; mem_wr = 0;
    step;
    chk("sim_if_req", b_req, 1); chk("sim_if_addr", b_addr, 32'h104); chk("sim_if_we", b_we, 0);
    bus_ack = 1; bus_dr = 32'h12345678;
    step;
    chk("sim_if_ack", if_ack, 1); chk("sim_if_data", if_data, 32'h12345678);
    bus_ack = 0; if_req = 0;
    step;

    // Alternation with zero-wait memory
    do_reset;
    if_req = 1; if_addr = 32'h200; mem_rd = 1; mem_addr = 32'h300;
    n = 0; ifa = 0; mema = 0;
    for (int c = 0; c < 16 && n < 4; c++) begin
      step;
      bus_ack = 0;
      if (if_ack) ifa++;
      if (mem_ack) mema++;
      if (b_req) begin seq[n] = b_addr; n++; bus_ack = 1; bus_dr = $urandom; end
    end
    step;
    if (if_ack) ifa++;
    if (mem_ack) mema++;
    bus_ack = 0; if_req = 0; mem_rd = 0;
    chk("alt_grants", n, 4);
    chk("alt_g0", seq[0], 32'h300); chk("alt_g1", seq[1], 32'h200);
    chk("alt_g2", seq[2], 32'h300); chk("alt_g3", seq[3], 32'h200);
    chk("alt_if_acks", ifa, 2); chk("alt_mem_acks", mema, 2);
    step;

    // Ack arriving on the last allowed busy cycle
    do_reset;
    mem_rd = 1; mem_addr = 32'h3000;
    step;
    for (int k = 1; k <= TMO; k++) begin
      if (k == TMO) begin
        chk("a64_req_held", b_req, 1);
        bus_ack = 1; bus_dr = 32'h77;
      end
      step;
    end
    chk("a64_ack", mem_ack, 1); chk("a64_data", mem_data, 32'h77); chk("a64_tmo", tmo, 0);
    bus_ack = 0; mem_rd = 0;
    step;
    chk("a64_tmo_after", tmo, 0);

    // Reset in the middle of an IF transfer
    if_req = 1; if_addr = 32'h180;
    step;
    chk("rmid_req", b_req, 1);
    step;
    nrst = 0; #1;
    chk("rmid_req_drop", b_req, 0); chk("rmid_if_ack", if_ack, 0);
    chk("rmid_mem_data", mem_data, 0); chk("rmid_addr", b_addr, 0); chk("rmid_if_data", if_data, 0);
    step;
    nrst = 1;
    step;
    chk("rmid_regrant", b_req, 1); chk("rmid_regrant_addr", b_addr, 32'h180);
    bus_ack = 1; bus_dr = 32'hCAFEF00D;
    step;
    chk("rmid_ack", if_ack, 1); chk("rmid_data", if_data, 32'hCAFEF00D);
    bus_ack = 0; if_req = 0;
    step;

    // Timeout: memory never answers
    mem_rd = 1; mem_addr = 32'h3000;
    step;
    cnt = 0;
    while (b_req && cnt < 100) begin cnt++; step; end
    chk("tmo_busy_cycles", cnt, TMO);
    chk("tmo_ack", mem_ack, 1); chk("tmo_data", mem_data, ERRD);
    chk("tmo_flag", tmo, 1); chk("tmo_req", b_req, 0);
    mem_rd = 0;
    step;
    chk("tmo_ack_pulse", mem_ack, 0); chk("tmo_sticky", tmo, 1);
    if_req = 1; if_addr = 32'h140;
    step;
    chk("post_tmo_req", b_req, 1); chk("post_tmo_addr", b_addr, 32'h140);
    bus_ack = 1; bus_dr = 32'h0BADF00D;
    step;
    chk("post_tmo_ack", if_ack, 1); chk("post_tmo_data", if_data, 32'h0BADF00D);
    chk("post_tmo_flag", tmo, 1);
    bus_ack = 0; if_req = 0;
    step;

    // Randomized traffic against the model
    do_reset;
    wait_left = -1;
    for (int c = 0; c < 4000; c++) begin
      step;
      if (c == 2000) begin do_reset; wait_left = -1; end
      bus_ack = 0;
      if (e_req) begin
        if (wait_left < 0) begin
          r = $urandom_range(0, 99);
          lat = (r < 70) ? $urandom_range(0, 2) : (r < 90) ? $urandom_range(3, 8) :
                (r < 94) ? 62 : (r < 97) ? 63 : 64;
          wait_left = lat;
        end
        if (wait_left == 0) begin bus_ack = 1; bus_dr = $urandom; wait_left = -1; end
        else wait_left--;
      end else begin
        wait_left = -1;
        if ($urandom_range(0, 99) < 5) begin bus_ack = 1; bus_dr = $urandom; end
      end
      if (if_req) begin
        if (e_if_ack) begin
          if ($urandom_range(0, 1) == 1) if_addr = $urandom; else if_req = 0;
        end else if ($urandom_range(0, 99) == 0) if_req = 0;
      end else if ($urandom_range(0, 99) < 30) begin
        if_req = 1; if_addr = $urandom;
      end
      if (mem_rd || mem_wr) begin
        if (e_mem_ack) begin
          if ($urandom_range(0, 1) == 1) begin mem_addr = $urandom; mem_dw = $urandom; end
          else begin mem_rd = 0; mem_wr = 0; end
        end else if ($urandom_range(0, 99) == 0) begin mem_rd = 0; mem_wr = 0; end
      end else if ($urandom_range(0, 99) < 30) begin
        r = $urandom_range(0, 2);
        mem_rd = (r != 1); mem_wr = (r != 0);
        mem_addr = $urandom; mem_dw = $urandom;
      end
    end
    if_req = 0; mem_rd = 0; mem_wr = 0; bus_ack = 0;
    step; step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
